program_memory: RTL
===================

PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 SHALL have parameter NB_DATA, default 32: instruction word width, a multiple of 8, minimum 8.
REQ-002 SHALL have parameter N_ADDR, default 2048: word depth, minimum 2.
REQ-003 SHALL have parameter NB_ADDR, default clog2(N_ADDR): fetch/write address width.
REQ-004 SHALL have parameter END_WORD, default all-ones: end-of-program marker word.
REQ-005 SHALL have parameter INIT_WORD, default 0: power-up content of every word.
REQ-006 SHALL have port i_clock, input, 1 bit: all logic on rising edge.
REQ-007 SHALL have port i_reset, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port i_enable, input, 1 bit: fetch enable.
REQ-009 SHALL have port i_addr, input, NB_ADDR bits: fetch word address.
REQ-010 SHALL have port o_data, output, NB_DATA bits: fetched word.
REQ-011 SHALL have port o_valid, output, 1 bit: o_data updated by a fetch this cycle.
REQ-012 SHALL have port i_load_start, input, 1 bit: begin program load.
REQ-013 SHALL have port i_load_byte, input, 8 bits: load data byte.
REQ-014 SHALL have port i_load_valid, input, 1 bit: i_load_byte valid.
REQ-015 SHALL have port o_load_ready, output, 1 bit: byte accepted when high together with i_load_valid.
REQ-016 SHALL have port o_load_done, output, 1 bit: load finished.
REQ-017 SHALL have port o_load_count, output, NB_ADDR+1 bits: words written in the current/last load.
REQ-018 SHALL have port o_parity_err, output, 1 bit: parity mismatch on the fetched word.

Function
REQ-019 SHALL use FSM states IDLE, LOAD, DONE.
- IDLE->LOAD and DONE->LOAD on i_load_start.
- LOAD->DONE on the end condition in REQ-023.
REQ-020 Fetch SHALL be permitted in IDLE and DONE.
- i_enable=1: o_data<=mem[i_addr], o_valid<=1 next cycle (latency 1).
- i_enable=0: o_data holds, o_valid<=0.
- i_addr>=N_ADDR: o_data<=0.
REQ-021 In LOAD, o_valid SHALL be 0, o_data SHALL hold, and o_load_ready SHALL be 1; o_load_ready SHALL be 0 in all other states.
REQ-022 Accepted bytes SHALL pack MSB-first.
- After NB_DATA/8 bytes, the word SHALL be written to mem[waddr] in the same edge as the last byte.
- waddr SHALL then increment and o_load_count SHALL increment.
REQ-023 LOAD SHALL enter DONE when either:
- the written word equals END_WORD (marker is stored and counted), or
- word N_ADDR-1 has been written.
REQ-024 o_load_done SHALL be 1 in DONE, 0 otherwise.
REQ-025 i_load_start SHALL, in any state including LOAD, reset waddr, byte counter and o_load_count to 0 and enter LOAD.
- A byte presented in the same cycle as i_load_start SHALL be dropped.
REQ-026 A partially assembled word SHALL never be written.

Reset
REQ-027 i_reset SHALL set the following, and SHALL take priority over all other inputs:
- state IDLE, o_data<=mem[0], o_valid 0, o_load_done 0, o_load_count 0, byte counter 0, o_parity_err 0.
REQ-028 Reset SHALL NOT alter memory contents; reset mid-LOAD SHALL discard the partial word only.

Configuration
REQ-029 With PROGRAM_MEMORY_PARITY_EN defined:
- an even-parity bit SHALL be stored per word on load (and computed for INIT_WORD).
- o_parity_err SHALL be registered with o_data and asserted when the recomputed parity differs from the stored bit.
REQ-030 Without PROGRAM_MEMORY_PARITY_EN, no parity storage SHALL exist and o_parity_err SHALL be tied 0.

Structure
REQ-031 Package program_memory_pkg SHALL hold the FSM state type, the BYTE_W=8 constant and the default END_WORD/INIT_WORD constants.
REQ-032 Byte assembly SHALL be a sub-module program_memory_byte_packer (byte counter, shift register, word-complete strobe).

Verification (NB_DATA=32, N_ADDR=16)
REQ-033 Power-up fetch: i_enable=1, addr 5 -> o_data=INIT_WORD, o_valid=1 one cycle later.
REQ-034 Load then fetch:
- start, bytes 12 34 56 78 AA BB CC DD FF FF FF FF -> o_load_count=3, o_load_done=1.
- fetch addr 1 -> 0xAABBCCDD.
REQ-035 Full load: 16 words without marker -> DONE after word 15, o_load_count=16.
REQ-036 Reset after 2 bytes of word 0 -> IDLE, mem[0] unchanged, o_load_count=0.
REQ-037 i_load_start asserted mid-LOAD with a valid byte -> byte dropped, next 4 bytes land at addr 0.
REQ-038 With macro: force a stored parity bit flip at addr 2, fetch addr 2 -> o_parity_err=1 with o_valid=1.

Source files
------------

// File: rtl/program_memory_pkg.sv
// Shared types and constants for the program memory block.
package program_memory_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned MAX_WORD_W = 1024;

  // Wide fill constants; users slice them down to their word width.
  localparam logic [MAX_WORD_W-1:0] DEFAULT_END_WORD  = '1;
  localparam logic [MAX_WORD_W-1:0] DEFAULT_INIT_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/program_memory_byte_packer.sv
// Assembles MSB-first bytes into words and strobes when a word is complete.
module program_memory_byte_packer
  import program_memory_pkg::*;
#(
  parameter int unsigned NB_DATA = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_byte_valid,
  input  logic [BYTE_W-1:0]  i_byte,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_done
);

  localparam int unsigned BYTES_PER_WORD = NB_DATA / BYTE_W;
  localparam int unsigned CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_DATA-1:0] word;
  logic               last;

  // Shift in the incoming byte; the completed word is visible combinationally
  // so it can be written on the same edge as its last byte.
  always_comb begin
    word             = shift_q << BYTE_W;
    word[BYTE_W-1:0] = i_byte;
    last             = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    shift_d          = shift_q;
    cnt_d            = cnt_q;
    if (i_reset || i_clear) begin
      cnt_d = '0;
    end else if (i_byte_valid) begin
      shift_d = word;
      cnt_d   = last ? '0 : cnt_q + 1'b1;
    end
  end

  // Byte counter and shift register.
  always_ff @(posedge i_clock) begin
    cnt_q   <= cnt_d;
    shift_q <= shift_d;
  end

  assign o_word      = word;
  assign o_word_done = i_byte_valid && last && !i_reset && !i_clear;

endmodule

// File: rtl/program_memory.sv
// Byte-loadable program memory with a single registered fetch port.
// Optional per-word even parity: define PROGRAM_MEMORY_PARITY_EN.
module program_memory
  import program_memory_pkg::*;
#(
  parameter int unsigned          NB_DATA   = 32,
  parameter int unsigned          N_ADDR    = 2048,
  parameter int unsigned          NB_ADDR   = $clog2(N_ADDR),
  parameter logic [NB_DATA-1:0]   END_WORD  = DEFAULT_END_WORD[NB_DATA-1:0],
  parameter logic [NB_DATA-1:0]   INIT_WORD = DEFAULT_INIT_WORD[NB_DATA-1:0]
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB_ADDR-1:0] i_addr,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  input  logic               i_load_start,
  input  logic [BYTE_W-1:0]  i_load_byte,
  input  logic               i_load_valid,
  output logic               o_load_ready,
  output logic               o_load_done,
  output logic [NB_ADDR:0]   o_load_count,
  output logic               o_parity_err
);

  logic [NB_DATA-1:0] mem [N_ADDR] = '{default: INIT_WORD};

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] waddr_q, waddr_d;
  logic [NB_ADDR:0]   count_q, count_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               valid_q, valid_d;

  logic               accept;
  logic               we;
  logic [NB_DATA-1:0] pk_word;
  logic [NB_ADDR-1:0] rd_addr;
  logic               rd_in_range;
  logic [NB_DATA-1:0] rd_word;
  logic               fetch;

  assign accept = (state_q == ST_LOAD) && i_load_valid && !i_load_start && !i_reset;

  program_memory_byte_packer #(
    .NB_DATA (NB_DATA)
  ) u_packer (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (i_load_start),
    .i_byte_valid (accept),
    .i_byte       (i_load_byte),
    .o_word       (pk_word),
    .o_word_done  (we)
  );

  // Read port: reset forces address 0 so o_data reloads mem[0].
  always_comb begin
    rd_addr     = i_reset ? '0 : i_addr;
    rd_in_range = ({1'b0, rd_addr} < (NB_ADDR+1)'(N_ADDR));
    rd_word     = rd_in_range ? mem[rd_addr] : '0;
    fetch       = i_reset || (i_enable && (state_q != ST_LOAD));
  end

  // FSM next state, write pointer, load count and fetch register.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    count_d = count_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (i_reset) begin
      state_d = ST_IDLE;
      waddr_d = '0;
      count_d = '0;
      data_d  = rd_word;
    end else begin
      if (fetch) begin
        data_d  = rd_word;
        valid_d = 1'b1;
      end
      if (i_load_start) begin
        state_d = ST_LOAD;
        waddr_d = '0;
        count_d = '0;
      end else if (state_q == ST_LOAD && we) begin
        waddr_d = waddr_q + 1'b1;
        count_d = count_q + 1'b1;
        if (pk_word == END_WORD || waddr_q == NB_ADDR'(N_ADDR - 1)) begin
          state_d = ST_DONE;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clock) begin
    state_q <= state_d;
    waddr_q <= waddr_d;
    count_q <= count_d;
    data_q  <= data_d;
    valid_q <= valid_d;
  end

  // Word write on the edge that completes it.
  always_ff @(posedge i_clock) begin
    if (we) begin
      mem[waddr_q] <= pk_word;
    end
  end

`ifdef PROGRAM_MEMORY_PARITY_EN
  logic par_mem [N_ADDR] = '{default: ^INIT_WORD};
  logic perr_q, perr_d;
  logic rd_par;

  // Parity check travels with the fetched word; out-of-range reads never flag.
  always_comb begin
    rd_par = rd_in_range ? par_mem[rd_addr] : 1'b0;
    perr_d = perr_q;
    if (i_reset) begin
      perr_d = 1'b0;
    end else if (fetch) begin
      perr_d = (^rd_word) != rd_par;
    end
  end

  // Parity storage and error register.
  always_ff @(posedge i_clock) begin
    if (we) begin
      par_mem[waddr_q] <= ^pk_word;
    end
    perr_q <= perr_d;
  end

  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_load_ready = (state_q == ST_LOAD);
  assign o_load_done  = (state_q == ST_DONE);
  assign o_load_count = count_q;

endmodule
